// File: rtl/cmd_decoder_pkg.sv
// +----------------------------------------------------------------------------+
// | cmd_decoder_pkg : shared framing bytes, channel count and FSM encoding     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package cmd_decoder_pkg;

  localparam logic [7:0] PREFIX   = 8'hA5;
  localparam logic [7:0] ADDR_AST = 8'h3C;
  localparam int         N_SRC    = 8;

  localparam int BYTE_W = 8;
  localparam int RAM_AW = 8;

  // Shared with the encoder so both debug views decode the same state value
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_GET_ADDR = 3'd1;
  localparam logic [2:0] ST_GET_DEST = 3'd2;
  localparam logic [2:0] ST_GET_LEN  = 3'd3;
  localparam logic [2:0] ST_GET_DATA = 3'd4;
  localparam logic [2:0] ST_GET_CRC  = 3'd5;
  localparam logic [2:0] ST_DRAIN    = 3'd6;

  function automatic logic [7:0] crc_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_decoder_pkt.sv
// +----------------------------------------------------------------------------+
// | pkt_ram : 256x8 simple dual-port packet buffer, synchronous 1-cycle read   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module pkt_ram
  import cmd_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [RAM_AW-1:0] wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic [RAM_AW-1:0] rd_addr,
  output logic [BYTE_W-1:0] rd_data
);

  logic [BYTE_W-1:0] mem_q [0:(1<<RAM_AW)-1];
  logic [BYTE_W-1:0] rd_data_q;

  // No reset: contents are only consumed after being written by a packet
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/cmd_decoder.sv
// +----------------------------------------------------------------------------+
// | cmd_decoder : framed command decoder, CRC check and per-destination drain  |
// | Optional inter-byte timeout enabled by macro CMD_DECODER_TIMEOUT_EN.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cmd_decoder
  import cmd_decoder_pkg::*;
#(
  parameter int N_DST       = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [7:0]       dst_data,
  output logic [N_DST-1:0] dst_wrreq,
  input  logic [N_DST-1:0] dst_full,
  output logic             pkt_ok,
  output logic             crc_err,
  output logic             fmt_err
);

  localparam int               DST_W    = $clog2(N_DST);
  localparam logic [8:0]       N_DST_9  = 9'(N_DST);
  localparam logic [N_DST-1:0] ONE_HOT0 = N_DST'(1);

  if (N_DST < 2 || N_DST > 256 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("cmd_decoder: N_DST or TIMEOUT_CYC out of range");
  end

  logic [2:0]       state_q,  state_d;
  logic [DST_W-1:0] dest_q,   dest_d;
  logic [7:0]       len_q,    len_d;
  logic [7:0]       wr_idx_q, wr_idx_d;
  logic [7:0]       rd_idx_q, rd_idx_d;
  logic [7:0]       crc_q,    crc_d;
  logic             pkt_ok_q, pkt_ok_d;
  logic             crc_err_q, crc_err_d;
  logic             fmt_err_q, fmt_err_d;

  logic       accept;
  logic       drain_fire;
  logic       ram_we;
  logic       tmo_hit;
  logic [7:0] ram_rdata;

  assign rx_ready   = (state_q != ST_DRAIN);
  assign accept     = rx_valid & rx_ready;
  assign drain_fire = (state_q == ST_DRAIN) & ~dst_full[dest_q];
  assign dst_wrreq  = drain_fire ? (ONE_HOT0 << dest_q) : '0;
  assign dst_data   = (state_q == ST_DRAIN) ? ram_rdata : 8'h00;
  assign pkt_ok     = pkt_ok_q;
  assign crc_err    = crc_err_q;
  assign fmt_err    = fmt_err_q;

`ifdef CMD_DECODER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d   = '0;
    tmo_hit = 1'b0;
    if ((state_q != ST_IDLE) && (state_q != ST_DRAIN) && !accept) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        tmo_hit = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    len_d     = len_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    crc_d     = crc_q;
    pkt_ok_d  = 1'b0;
    crc_err_d = 1'b0;
    fmt_err_d = 1'b0;
    ram_we    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept && rx_data == PREFIX) begin
          state_d = ST_GET_ADDR;
        end
      end
      ST_GET_ADDR: begin
        // A repeated PREFIX is treated as the start of a fresh frame
        if (accept) begin
          if (rx_data == ADDR_AST) begin
            state_d = ST_GET_DEST;
          end else if (rx_data != PREFIX) begin
            fmt_err_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_GET_DEST: begin
        if (accept) begin
          if ({1'b0, rx_data} >= N_DST_9) begin
            fmt_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            dest_d  = rx_data[DST_W-1:0];
            state_d = ST_GET_LEN;
          end
        end
      end
      ST_GET_LEN: begin
        if (accept) begin
          if (rx_data == 8'd0) begin
            fmt_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            len_d    = rx_data;
            wr_idx_d = 8'd0;
            crc_d    = 8'd0;
            state_d  = ST_GET_DATA;
          end
        end
      end
      ST_GET_DATA: begin
        if (accept) begin
          ram_we = 1'b1;
          crc_d  = crc_add(crc_q, rx_data);
          if (wr_idx_q == len_q - 8'd1) begin
            state_d = ST_GET_CRC;
          end else begin
            wr_idx_d = wr_idx_q + 8'd1;
          end
        end
      end
      ST_GET_CRC: begin
        if (accept) begin
          if (rx_data == crc_q) begin
            pkt_ok_d = 1'b1;
            rd_idx_d = 8'd0;
            state_d  = ST_DRAIN;
          end else begin
            crc_err_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_fire) begin
          if (rd_idx_q == len_q - 8'd1) begin
            rd_idx_d = 8'd0;
            state_d  = ST_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (tmo_hit) begin
      fmt_err_d = 1'b1;
      state_d   = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      dest_q    <= '0;
      len_q     <= 8'd0;
      wr_idx_q  <= 8'd0;
      rd_idx_q  <= 8'd0;
      crc_q     <= 8'd0;
      pkt_ok_q  <= 1'b0;
      crc_err_q <= 1'b0;
      fmt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      len_q     <= len_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      crc_q     <= crc_d;
      pkt_ok_q  <= pkt_ok_d;
      crc_err_q <= crc_err_d;
      fmt_err_q <= fmt_err_d;
    end
  end

  // Read address tracks the next index so the byte is already on dst_data when DRAIN presents it
  pkt_ram u_pkt_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (wr_idx_q),
    .wr_data (rx_data),
    .rd_addr (rd_idx_d),
    .rd_data (ram_rdata)
  );

endmodule

`default_nettype wire

// File: doc/cmd_decoder.md
CMD_DECODER -- requirements
Module: cmd_decoder

Interface
REQ-001 SHALL have parameter N_DST, default 8: number of destination channels, from 2 to 256.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1000: inter-byte timeout in clk cycles; used only under REQ-030.
REQ-003 SHALL have port clk, in, 1: clock, rising edge.
REQ-004 SHALL have port n_rst, in, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port rx_data, in, 8: received byte.
REQ-006 SHALL have port rx_valid, in, 1: rx_data is valid.
REQ-007 SHALL have port rx_ready, out, 1: decoder accepts a byte this cycle.
REQ-008 SHALL have port dst_data, out, 8: payload byte, shared by all destinations.
REQ-009 SHALL have port dst_wrreq, out, N_DST: one-hot write strobe, one bit per destination.
REQ-010 SHALL have port dst_full, in, N_DST: destination cannot take data.
REQ-011 SHALL have port pkt_ok, out, 1: one-cycle pulse when a packet passes its CRC check.
REQ-012 SHALL have port crc_err, out, 1: one-cycle pulse when a packet fails its CRC check.
REQ-013 SHALL have port fmt_err, out, 1: one-cycle pulse on a format error or a timeout.

Function
REQ-014 SHALL accept a byte only in a cycle where rx_valid and rx_ready are both high.
- rx_ready is high in every state except DRAIN.
REQ-015 SHALL decode the frame PREFIX, ADDR_AST, DEST, LEN, DATA[1..LEN], CRC, one byte each.
REQ-016 SHALL use states IDLE, GET_ADDR, GET_DEST, GET_LEN, GET_DATA, GET_CRC, DRAIN.
- Each accepted byte advances one state.
- GET_DATA stays in place until it has accepted LEN bytes.
REQ-017 SHALL, in IDLE, discard any byte other than PREFIX and leave all flags low.
REQ-018 SHALL handle a bad ADDR byte as follows:
- ADDR byte equal to PREFIX: stay in GET_ADDR (resync).
- Any other non-ADDR_AST value: fmt_err pulse, go to IDLE.
REQ-019 SHALL, on DEST >= N_DST or LEN == 0, pulse fmt_err and go to IDLE.
REQ-020 SHALL write DATA bytes into the packet buffer at addresses 0..LEN-1.
- CRC is the 8-bit modulo-256 sum of the DATA bytes.
REQ-021 SHALL, on a CRC byte that matches, pulse pkt_ok in the cycle after acceptance and enter DRAIN.
REQ-022 SHALL, on a CRC byte that does not match, pulse crc_err in the cycle after acceptance and go to IDLE.
- No dst_wrreq is asserted for that packet.
REQ-023 SHALL, in DRAIN, deliver the LEN buffered bytes in order, then return to IDLE.
- dst_wrreq[DEST] and dst_data are valid in the same cycle.
- dst_wrreq[DEST] is never high while dst_full[DEST] is high.
- A full destination stalls DRAIN without losing or repeating a byte.
REQ-024 SHALL deliver one byte per cycle during DRAIN while dst_full[DEST] stays low.
REQ-025 SHALL keep dst_wrreq all-zero outside DRAIN.
- At most one bit of dst_wrreq is high in any cycle.
REQ-026 SHALL allow a packet with LEN = 255 without counter wrap.
- Counters are 8-bit; comparisons are made before increment.

Reset
REQ-027 SHALL, while n_rst is low, force:
- state = IDLE; rx_ready = 1.
- dst_wrreq = 0; dst_data = 0.
- pkt_ok = 0; crc_err = 0; fmt_err = 0.
- All counters and the CRC accumulator = 0.
REQ-028 SHALL, on reset asserted mid-packet or mid-DRAIN, abandon the packet.
- No further dst_wrreq is issued for it after reset is released.
REQ-029 SHALL not require the buffer RAM contents to be reset.

Configuration
REQ-030 SHALL, when macro CMD_DECODER_TIMEOUT_EN is defined, apply an inter-byte timeout:
- Applies in GET_ADDR through GET_CRC.
- After TIMEOUT_CYC consecutive cycles with no accepted byte: fmt_err pulse, go to IDLE.
- The cycle counter restarts on each accepted byte.
REQ-031 SHALL, when CMD_DECODER_TIMEOUT_EN is undefined, contain no timeout logic; a partial frame waits indefinitely.

Structure
REQ-032 SHALL take PREFIX, ADDR_AST and N_SRC from the shared defines package; N_DST is set to N_SRC at instantiation.
REQ-033 SHALL put the state encoding localparams in the shared package so the encoder and decoder debug views match.
REQ-034 SHALL instantiate one sub-module, pkt_ram: 256x8 simple dual-port RAM with synchronous read and 1-cycle read latency.

Verification
REQ-035 SHALL cover a good packet:
- Stimulus: PREFIX, ADDR_AST, 0x02, 0x03, 0x10, 0x20, 0x30, CRC 0x60.
- Response: pkt_ok pulses; dst_wrreq[2] is high for 3 cycles with dst_data 0x10, 0x20, 0x30.
REQ-036 SHALL cover a bad CRC:
- Stimulus: same frame with CRC 0x61.
- Response: crc_err pulses once; dst_wrreq stays 0.
REQ-037 SHALL cover a bad destination:
- Stimulus: DEST = N_DST.
- Response: fmt_err pulses after the DEST byte; the next good frame decodes normally.
REQ-038 SHALL cover back-pressure:
- Stimulus: good packet with LEN 4; dst_full[2] held high for 5 cycles during DRAIN.
- Response: all 4 bytes are delivered in order; no write occurs while full; rx_ready stays low until DRAIN ends.
REQ-039 SHALL cover boundaries:
- Frame with LEN 255 (all bytes 0xFF, CRC 0x01): correct delivery.
- Garbage bytes, then PREFIX, PREFIX, ADDR_AST, ...: the packet decodes after resync.
REQ-040 SHALL cover the timeout with CMD_DECODER_TIMEOUT_EN and TIMEOUT_CYC = 10:
- Stimulus: stop input after the LEN byte.
- Response: fmt_err pulses 10 cycles later and state returns to IDLE.
